approx_adder_error_monitor: RTL

//  Sequential checker at the output end of the approximate ripple-carry adders.

---
 rtl/approx_adder_error_monitor.sv | 120 ++++++++++++
 1 files changed

// File: rtl/approx_adder_error_monitor.sv
// Error-statistics checker for approximate adders: recomputes the exact sum and
// accumulates sum/max of absolute error and the erroneous-sample count over a run.
module approx_adder_error_monitor #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 40,
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx_out,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sae,
  output logic [WIDTH:0]   max_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             sat
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | accepting samples until n_latched have been taken
  // DRAIN | last sample still in stage 1
  // DONE  | results final and held
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_latched, accepted;
  logic             s1_valid;
  logic [WIDTH+1:0] s1_diff;

  logic             accept, start_ok;
  logic [WIDTH:0]   exact_c;
  logic [WIDTH+1:0] diff_c, neg_diff;
  logic [WIDTH:0]   ae;
  logic [ACC_W:0]   sae_sum;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    start_ok = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          start_ok = 1'b1;
          state_nx = (n_samples == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = (accepted < n_latched);
        accept   = in_valid & in_ready;
        if (accept && (accepted == n_latched - 1'b1))
          state_nx = DRAIN;
      end
      // Stage 2 retires the last sample on this edge, so the pipeline is empty after it.
      DRAIN: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);

  assign exact_c  = {1'b0, in1} + {1'b0, in2};
  assign diff_c   = {1'b0, approx_out} - {1'b0, exact_c};
  assign neg_diff = -s1_diff;
  // Magnitude always fits WIDTH+1 bits since both operands of the difference do.
  assign ae       = s1_diff[WIDTH+1] ? neg_diff[WIDTH:0] : s1_diff[WIDTH:0];
  assign sae_sum  = {1'b0, sae} + {{(ACC_W - WIDTH){1'b0}}, ae};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      n_latched <= '0;
      accepted  <= '0;
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      sae       <= '0;
      max_err   <= '0;
      err_cnt   <= '0;
      sat       <= 1'b0;
    end else begin
      state    <= state_nx;
      done     <= (start_ok && (n_samples == '0)) || (state == DRAIN);
      s1_valid <= accept;
      if (accept)
        s1_diff <= diff_c;
      if (start_ok) begin
        n_latched <= n_samples;
        accepted  <= '0;
        sae       <= '0;
        max_err   <= '0;
        err_cnt   <= '0;
        sat       <= 1'b0;
      end else begin
        if (accept)
          accepted <= accepted + 1'b1;
        if (s1_valid) begin
          if (sae_sum[ACC_W]) begin
            sae <= '1;
            sat <= 1'b1;
          end else begin
            sae <= sae_sum[ACC_W-1:0];
          end
          if (ae > max_err)
            max_err <= ae;
          if (ae != '0)
            err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule
